clken_divider: RTL and testbench

- Parametrised, multi-channel successor to the board clock divider.
- Generates single-cycle clock-enable pulses at runtime-programmable integer divide ratios from one fast clock, instead of separate divided clocks on global buffers.
- Holds all enables off until an external lock/start condition has been stable for 2^Nstart cycles.
- Sits beside the MMCM output, drives enables for memIO, mips, and I/O blocks all clocked on clk100.

---
 rtl/clken_divider.sv | 119 +++++++++++
 tb/tb_clken_divider.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/clken_divider.sv
// Multi-channel clock-enable generator: one-cycle enable pulses at runtime-programmable
// integer ratios of clk, held off until the lock input has been stable for 2^Nstart cycles.
module clken_divider #(
    parameter int unsigned Nchan    = 4,
    parameter int unsigned Wdiv     = 8,
    parameter int unsigned Nstart   = 2,
    parameter logic [Nchan*Wdiv-1:0] DIV_INIT = {8'd8, 8'd4, 8'd2, 8'd1}
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        locked,
    input  logic                                        run,
    input  logic                                        align,
    input  logic                                        wr,
    input  logic [((Nchan > 1) ? $clog2(Nchan) : 1)-1:0] wr_chan,
    input  logic [Wdiv-1:0]                             wr_div,
    output logic                                        ready,
    output logic [Nchan-1:0]                            en
);

    localparam int unsigned WS = Nstart + 1;

    logic [WS-1:0]    start_q, start_d;
    logic [Nchan-1:0] en_q, en_d;
    logic [Nchan-1:0] pflag_q, pflag_d;
    logic [Wdiv-1:0]  cnt_q  [Nchan];
    logic [Wdiv-1:0]  cnt_d  [Nchan];
    logic [Wdiv-1:0]  div_q  [Nchan];
    logic [Wdiv-1:0]  div_d  [Nchan];
    logic [Wdiv-1:0]  pend_q [Nchan];
    logic [Wdiv-1:0]  pend_d [Nchan];

    logic             rdy;
    logic             act;
    logic [Nchan-1:0] term;
    logic [Nchan-1:0] apply;
    logic [Nchan-1:0] wr_hit;

    assign rdy   = start_q[Nstart];
    assign act   = rdy & run;
    assign ready = rdy;
    assign en    = en_q;

    // Startup counter saturates once its top bit (ready) is set; any lock drop restarts it.
    always_comb begin
        start_d = start_q;
        if (!locked) begin
            start_d = '0;
        end else if (!rdy) begin
            start_d = start_q + WS'(1);
        end
    end

    // Per-channel counting and ratio update. A ratio is "applied" at any point where the
    // counter is known to be at zero afterwards, so cnt < div always holds.
    always_comb begin
        term   = '0;
        apply  = '0;
        wr_hit = '0;
        en_d   = '0;
        for (int i = 0; i < Nchan; i++) begin
            cnt_d[i]   = cnt_q[i];
            div_d[i]   = div_q[i];
            pend_d[i]  = pend_q[i];
            pflag_d[i] = pflag_q[i];

            term[i]   = act && (div_q[i] != '0) && (cnt_q[i] == div_q[i] - Wdiv'(1));
            apply[i]  = !locked || !rdy || align || (div_q[i] == '0) || term[i];
            wr_hit[i] = wr && (32'(wr_chan) == 32'(i));

            if (!locked || (rdy && align)) begin
                cnt_d[i] = '0;
            end else if (act) begin
                if (div_q[i] == '0 || term[i]) begin
                    cnt_d[i] = '0;
                    en_d[i]  = term[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + Wdiv'(1);
                end
            end

            if (wr_hit[i]) begin
                pend_d[i] = wr_div;
                if (apply[i]) begin
                    div_d[i]   = wr_div;
                    pflag_d[i] = 1'b0;
                end else begin
                    pflag_d[i] = 1'b1;
                end
            end else if (apply[i] && pflag_q[i]) begin
                div_d[i]   = pend_q[i];
                pflag_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q <= '0;
            en_q    <= '0;
            pflag_q <= '0;
            for (int i = 0; i < Nchan; i++) begin
                cnt_q[i]  <= '0;
                div_q[i]  <= DIV_INIT[i*Wdiv +: Wdiv];
                pend_q[i] <= DIV_INIT[i*Wdiv +: Wdiv];
            end
        end else begin
            start_q <= start_d;
            en_q    <= en_d;
            pflag_q <= pflag_d;
            for (int i = 0; i < Nchan; i++) begin
                cnt_q[i]  <= cnt_d[i];
                div_q[i]  <= div_d[i];
                pend_q[i] <= pend_d[i];
            end
        end
    end

endmodule

// File: tb/tb_clken_divider.sv
// Directed bench for clken_divider: expected {ready,en} values are queued per cycle tag
// by the stimulus and checked by an independent negedge monitor.
module tb_clken_divider;

    logic       clk = 1'b0;
    logic       reset;
    logic       locked;
    logic       run;
    logic       align;
    logic       wr;
    logic [1:0] wr_chan;
    logic [7:0] wr_div;
    logic       ready;
    logic [3:0] en;

    clken_divider #(
        .Nchan   (4),
        .Wdiv    (8),
        .Nstart  (2),
        .DIV_INIT({8'd8, 8'd4, 8'd2, 8'd1})
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .locked (locked),
        .run    (run),
        .align  (align),
        .wr     (wr),
        .wr_chan(wr_chan),
        .wr_div (wr_div),
        .ready  (ready),
        .en     (en)
    );

    always #5 clk = ~clk;

    // Number of posedges seen so far; an expectation tagged N is the state after posedge N.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         tag;
        logic       rdy;
        logic [3:0] mask;
        logic [3:0] en;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   checks   = 0;
    int   errors   = 0;
    bit   done     = 1'b0;
    int   done_cyc = 0;

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].tag <= cyc) begin
            e = sb_q.pop_front();
            checks++;
            if (e.tag != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d",
                         e.name, e.tag, cyc);
            end else if (ready !== e.rdy || (en & e.mask) !== (e.en & e.mask)) begin
                errors++;
                $display("FAIL %s cycle %0d: got ready=%b en=%b, required ready=%b en=%b (mask %b)",
                         e.name, cyc, ready, en, e.rdy, e.en, e.mask);
            end
        end
        if (done) begin
            if (sb_q.size() == 0) begin
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end else if (cyc > done_cyc + 50) begin
                checks++;
                errors++;
                $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int tg, input logic r, input logic [3:0] m,
                        input logic [3:0] ex, input string nm);
        sb_q.push_back('{tg, r, m, ex, nm});
    endtask

    function automatic logic pulse(input int t, input int first, input int period);
        return (t >= first) && (((t - first) % period) == 0);
    endfunction

    // Enables for four channels that all restarted from zero with first active edge r+1.
    function automatic logic [3:0] pat(input int t, input int r,
                                       input int d0, input int d1, input int d2, input int d3);
        return {pulse(t, r + d3, d3), pulse(t, r + d2, d2), pulse(t, r + d1, d1), pulse(t, r + d0, d0)};
    endfunction

    int         r1, c0, r2, p0, q0, e0, f0, g0;
    logic [3:0] ev;

    initial begin
        reset = 1'b0; locked = 1'b0; run = 1'b0; align = 1'b0;
        wr = 1'b0; wr_chan = 2'd0; wr_div = 8'd0;

        step(1);
        push(cyc, 1'b0, 4'hF, 4'h0, "reset_state");
        step(2);

        // Startup: ready after 4 locked posedges, then default ratios 1/2/4/8.
        reset = 1'b1; locked = 1'b1; run = 1'b1;
        r1 = cyc + 4;
        for (int t = cyc + 1; t < r1; t++) push(t, 1'b0, 4'hF, 4'h0, "startup");
        for (int t = r1; t <= r1 + 24; t++) push(t, 1'b1, 4'hF, pat(t, r1, 1, 2, 4, 8), "steady");
        step(r1 + 24 - cyc);

        // One-cycle lock loss: outputs drop next cycle, startup repeats, channels restart in phase.
        c0 = cyc;
        r2 = c0 + 5;
        for (int t = c0 + 1; t < r2; t++) push(t, 1'b0, 4'hF, 4'h0, "relock");
        for (int t = r2; t <= r2 + 24; t++) push(t, 1'b1, 4'hF, pat(t, r2, 1, 2, 4, 8), "relock_phase");
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        step(r2 + 24 - cyc);

        // Channel 2 pending write 5 then 3 mid-period: old spacing until terminal, then 3.
        p0 = cyc;
        for (int t = p0 + 1; t <= p0 + 13; t++) begin
            ev = pat(t, r2, 1, 2, 4, 8);
            ev[2] = (t <= p0 + 4) ? pulse(t, r2 + 4, 4) : pulse(t, p0 + 4, 3);
            push(t, 1'b1, 4'hF, ev, "ratio_pending");
        end
        wr = 1'b1; wr_chan = 2'd2; wr_div = 8'd5;
        step(1);
        wr_div = 8'd3;
        step(1);
        wr = 1'b0;

        // Channel 1 disabled at its next terminal, then re-enabled immediately with ratio 6.
        step(p0 + 14 - cyc);
        q0 = cyc;
        for (int t = q0 + 1; t <= q0 + 20; t++) begin
            ev = pat(t, r2, 1, 2, 4, 8);
            ev[2] = pulse(t, p0 + 4, 3);
            ev[1] = (t <= q0 + 2) ? pulse(t, r2 + 2, 2) : pulse(t, q0 + 12, 6);
            push(t, 1'b1, 4'hF, ev, "ratio_zero_then_6");
        end
        wr = 1'b1; wr_chan = 2'd1; wr_div = 8'd0;
        step(1);
        wr = 1'b0;
        step(4);
        wr = 1'b1; wr_div = 8'd6;
        step(1);
        wr = 1'b0;

        // Pause with channel 3 at count 5: everything frozen, then 3 more cycles to its pulse.
        step(q0 + 23 - cyc);
        e0 = cyc;
        for (int t = e0 + 1; t <= e0 + 10; t++) push(t, 1'b1, 4'hF, 4'h0, "pause");
        push(e0 + 11, 1'b1, 4'b1001, 4'b0001, "resume");
        push(e0 + 12, 1'b1, 4'b1001, 4'b0001, "resume");
        push(e0 + 13, 1'b1, 4'b1001, 4'b1001, "resume_pulse");
        run = 1'b0;
        step(10);
        run = 1'b1;

        // Align: all counters restart together with ratios 1/6/3/8.
        step(e0 + 20 - cyc);
        f0 = cyc;
        push(f0 + 1, 1'b1, 4'hF, 4'h0, "align");
        for (int t = f0 + 2; t <= f0 + 25; t++)
            push(t, 1'b1, 4'hF, pat(t, f0 + 1, 1, 6, 3, 8), "post_align");
        align = 1'b1;
        step(1);
        align = 1'b0;

        // Asynchronous reset between edges while en[0] is high.
        step(f0 + 26 - cyc);
        g0 = cyc;
        push(g0, 1'b0, 4'hF, 4'h0, "async_reset");
        push(g0 + 1, 1'b0, 4'hF, 4'h0, "reset_hold");
        #2;
        reset = 1'b0;
        step(2);
        done_cyc = cyc;
        done = 1'b1;
    end

endmodule
